// File: rtl/mvm_ctrl.sv
// mvm_ctrl: command/data sequencer in front of the mvm unit.
// Buffers packets, issues gap-free mvm loads, captures results into a FIFO.
module mvm_ctrl #(
  parameter int M  = 8,
  parameter int IW = 12,
  parameter int OW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  output logic          cmd_ready,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          out_ready,
  output logic          err,
  output logic          busy,
  output logic          mvm_loadMatrix,
  output logic          mvm_loadVector,
  output logic          mvm_start,
  output logic [IW-1:0] mvm_data_in,
  input  logic          mvm_done,
  input  logic [OW-1:0] mvm_data_out
);
  localparam int MM = M * M;
  localparam int AW = $clog2(MM);
  localparam int NW = $clog2(MM + 1);
  localparam int PW = $clog2(M);
  localparam int CW = $clog2(M + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE,
    S_STREAM,
    S_START,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t        state_q, state_d;
  logic          kind_q, kind_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] wr_q, wr_d;
  logic [NW-1:0] rd_q, rd_d;
  logic [CW-1:0] cap_q, cap_d;
  logic          mat_ok_q, mat_ok_d;
  logic          vec_ok_q, vec_ok_d;
  logic          err_q, err_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] pbuf [MM];
  logic [OW-1:0] fifo [M];

  logic cmd_fire, in_fire, push, pop;

  assign cmd_ready      = (state_q == S_IDLE) && !reset;
  assign in_ready       = (state_q == S_COLLECT);
  assign busy           = (state_q != S_IDLE);
  assign err            = err_q;
  assign mvm_loadMatrix = (state_q == S_ISSUE) && !kind_q;
  assign mvm_loadVector = (state_q == S_ISSUE) && kind_q;
  assign mvm_start      = (state_q == S_START) && (cnt_q == '0);
  assign mvm_data_in    = (state_q == S_STREAM) ?
                          pbuf[rd_q[AW-1:0]] : '0;
  assign out_valid      = (cnt_q != '0);
  assign out_data       = out_valid ? fifo[rp_q] : '0;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;
  assign push     = (state_q == S_CAPTURE);
  assign pop      = out_valid && out_ready;

  // Sequencer next state: collect, issue, stream, start, capture.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    n_d      = n_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cap_d    = cap_q;
    mat_ok_d = mat_ok_q;
    vec_ok_d = vec_ok_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            2'd0: begin
              n_d     = NW'(MM);
              kind_d  = 1'b0;
              wr_d    = '0;
              state_d = S_COLLECT;
            end
            2'd1: begin
              n_d     = NW'(M);
              kind_d  = 1'b1;
              wr_d    = '0;
              state_d = S_COLLECT;
            end
            2'd2: begin
              if (mat_ok_q && vec_ok_q) state_d = S_START;
              else err_d = 1'b1;
            end
            2'd3: err_d = 1'b1;
          endcase
        end
      end
      S_COLLECT: begin
        if (in_fire) begin
          wr_d = wr_q + NW'(1);
          if (wr_q == n_q - NW'(1)) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_d    = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        rd_d = rd_q + NW'(1);
        if (rd_q == n_q - NW'(1)) begin
          if (kind_q) vec_ok_d = 1'b1;
          else mat_ok_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == '0) state_d = S_WAIT;
      end
      S_WAIT: begin
        cap_d = '0;
        if (mvm_done) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_d = cap_q + CW'(1);
        if (cap_q == CW'(M - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result FIFO pointers and occupancy.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = (wp_q == PW'(M - 1)) ? '0 : wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = (rp_q == PW'(M - 1)) ? '0 : rp_q + PW'(1);
    end
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kind_q   <= 1'b0;
      n_q      <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cap_q    <= '0;
      mat_ok_q <= 1'b0;
      vec_ok_q <= 1'b0;
      err_q    <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      n_q      <= n_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cap_q    <= cap_d;
      mat_ok_q <= mat_ok_d;
      vec_ok_q <= vec_ok_d;
      err_q    <= err_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Packet buffer and result FIFO storage.
  always_ff @(posedge clk) begin
    if (in_fire) pbuf[wr_q[AW-1:0]] <= in_data;
    if (push) fifo[wp_q] <= mvm_data_out;
  end

endmodule

// File: tb/tb_mvm_ctrl.sv
// tb_mvm_ctrl: directed bench for mvm_ctrl.
// A behavioural mvm stand-in returns preset result words after each start.
module tb_mvm_ctrl;
  localparam int M  = 8;
  localparam int IW = 12;
  localparam int OW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          err;
  logic          busy;
  logic          mvm_loadMatrix;
  logic          mvm_loadVector;
  logic          mvm_start;
  logic [IW-1:0] mvm_data_in;
  logic          mvm_done;
  logic [OW-1:0] mvm_data_out;

  always #5 clk = ~clk;

  mvm_ctrl #(.M(M), .IW(IW), .OW(OW)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_ready(cmd_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .err(err),
    .busy(busy),
    .mvm_loadMatrix(mvm_loadMatrix),
    .mvm_loadVector(mvm_loadVector),
    .mvm_start(mvm_start),
    .mvm_data_in(mvm_data_in),
    .mvm_done(mvm_done),
    .mvm_data_out(mvm_data_out)
  );

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int acc_cyc = 0;
  int last_in_cyc = 0;
  int err_cnt = 0;
  int st_cnt = 0;
  int st_cyc = 0;
  int st_osz = 0;
  int done_cyc = 0;
  int first_ov_cyc = 0;
  logic ov_prev = 1'b0;
  int lm_cnt = 0;
  int lm_cyc = 0;
  int lv_cnt = 0;
  int lv_cyc = 0;
  int slog_idx = 0;
  int slog_n = 0;
  logic [IW-1:0] slog [64];
  logic [OW-1:0] outq [$];
  int wbuf [64];
  int res [24];
  int run = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int k;
    cmd_valid = 1'b1;
    cmd_op = op;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      tick();
      k++;
    end
    chk("cmd_accept_wait", 64'(k < 2000), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int k;
      in_valid = 1'b1;
      in_data = IW'(wbuf[i]);
      k = 0;
      while (!in_ready && k < 100) begin
        tick();
        k++;
      end
      tick();
      in_valid = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic wait_idle(input bit drain);
    int k;
    k = 0;
    while ((busy || (drain && out_valid)) && k < 3000) begin
      tick();
      k++;
    end
    chk("idle_wait", 64'(k < 3000), 64'd1);
  endtask

  // Observe DUT activity between clock edges.
  always @(negedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (in_valid && in_ready) last_in_cyc = cyc;
    if (err) err_cnt++;
    if (mvm_start) begin
      st_cnt++;
      st_cyc = cyc;
      st_osz = outq.size();
    end
    if (mvm_done) done_cyc = cyc;
    if (out_valid && !ov_prev) first_ov_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) outq.push_back(out_data);
    if (slog_idx < slog_n) begin
      slog[slog_idx] = mvm_data_in;
      slog_idx++;
    end
    if (mvm_loadMatrix) begin
      lm_cnt++;
      lm_cyc = cyc;
      slog_idx = 0;
      slog_n = 64;
    end
    if (mvm_loadVector) begin
      lv_cnt++;
      lv_cyc = cyc;
      slog_idx = 0;
      slog_n = 8;
    end
  end

  // mvm stand-in: done two cycles after start, then M result words.
  initial begin
    mvm_done = 1'b0;
    mvm_data_out = '0;
    forever begin
      @(negedge clk);
      if (mvm_start) begin
        repeat (2) @(posedge clk);
        #1 mvm_done = 1'b1;
        @(posedge clk);
        #1 mvm_done = 1'b0;
        for (int j = 0; j < M; j++) begin
          mvm_data_out = OW'(res[run * M + j]);
          @(posedge clk);
          #1;
        end
        mvm_data_out = '0;
        run++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, c0, e0, s0;
    logic [IW-1:0] ew;
    logic [OW-1:0] eo;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      res[i] = i + 1;
      res[8 + i] = 101 + i;
      res[16 + i] = -(i + 1);
    end

    repeat (3) tick();
    chk("rst_outs", 64'({cmd_ready, in_ready, out_valid, err, busy,
        mvm_loadMatrix, mvm_loadVector, mvm_start}), 64'd0);
    chk("rst_data", 64'({mvm_data_in, out_data}), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_quiet", 64'({in_ready, out_valid, err, busy}), 64'd0);

    // Matrix load -32..31, no gaps.
    for (int i = 0; i < 64; i++) wbuf[i] = i - 32;
    send_cmd(2'd0);
    c0 = acc_cyc;
    send_words(64, 1'b0);
    wait_idle(1'b0);
    chk("mat_load_pulses", 64'(lm_cnt), 64'd1);
    chk("mat_issue_lat", 64'(lm_cyc - c0), 64'd65);
    chk("mat_stream_len", 64'(slog_idx), 64'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      ew = IW'(i - 32);
      if (slog[i] !== ew) bad++;
    end
    chk("mat_stream_bad", 64'(bad), 64'd0);
    chk("mat_first_word", 64'(slog[0]), 64'hFE0);
    chk("mat_last_word", 64'(slog[63]), 64'h01F);
    chk("mat_busy_after", 64'(busy), 64'd0);

    // Vector load 1..8 with in_valid toggling.
    for (int i = 0; i < 8; i++) wbuf[i] = i + 1;
    send_cmd(2'd1);
    send_words(8, 1'b1);
    wait_idle(1'b0);
    chk("vec_load_pulses", 64'(lv_cnt), 64'd1);
    chk("vec_issue_after_last", 64'(lv_cyc - last_in_cyc), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      ew = IW'(i + 1);
      if (slog[i] !== ew) bad++;
    end
    chk("vec_stream_bad", 64'(bad), 64'd0);
    chk("vec_stream_len", 64'(slog_idx), 64'd8);

    // Identity matrix, compute, consumer always ready.
    for (int i = 0; i < 64; i++) wbuf[i] = ((i / 8) == (i % 8)) ? 1 : 0;
    send_cmd(2'd0);
    send_words(64, 1'b0);
    wait_idle(1'b0);
    chk("id_load_pulses", 64'(lm_cnt), 64'd2);
    out_ready = 1'b1;
    outq.delete();
    send_cmd(2'd2);
    c0 = acc_cyc;
    wait_idle(1'b1);
    chk("cmp_starts", 64'(st_cnt), 64'd1);
    chk("cmp_start_lat", 64'(st_cyc - c0), 64'd1);
    chk("cmp_first_valid", 64'(first_ov_cyc - done_cyc), 64'd2);
    chk("cmp_beats", 64'(outq.size()), 64'd8);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      eo = OW'(i + 1);
      if (outq.size() <= i || outq[i] !== eo) bad++;
    end
    chk("cmp_data_bad", 64'(bad), 64'd0);

    // Rejected computes after a fresh reset.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    e0 = err_cnt;
    s0 = st_cnt;
    send_cmd(2'd2);
    repeat (3) tick();
    chk("rej_cmp_err", 64'(err_cnt - e0), 64'd1);
    chk("rej_cmp_nostart", 64'(st_cnt), 64'(s0));
    chk("rej_cmp_idle", 64'(busy), 64'd0);
    send_cmd(2'd3);
    repeat (3) tick();
    chk("rej_op3_err", 64'(err_cnt - e0), 64'd2);
    chk("rej_op3_nostart", 64'(st_cnt), 64'(s0));

    // Two computes with the consumer stalled.
    for (int i = 0; i < 64; i++) wbuf[i] = ((i / 8) == (i % 8)) ? 1 : 0;
    send_cmd(2'd0);
    send_words(64, 1'b0);
    wait_idle(1'b0);
    for (int i = 0; i < 8; i++) wbuf[i] = i + 1;
    send_cmd(2'd1);
    send_words(8, 1'b0);
    wait_idle(1'b0);
    out_ready = 1'b0;
    outq.delete();
    s0 = st_cnt;
    send_cmd(2'd2);
    send_cmd(2'd2);
    repeat (20) tick();
    chk("bp_one_start", 64'(st_cnt - s0), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_head", 64'(out_data), 64'd101);
    chk("bp_held_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle(1'b1);
    chk("bp_two_starts", 64'(st_cnt - s0), 64'd2);
    chk("bp_start_after_drain", 64'(st_osz), 64'd8);
    chk("bp_beats", 64'(outq.size()), 64'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      eo = (i < 8) ? OW'(101 + i) : OW'(-(i - 7));
      if (outq.size() <= i || outq[i] !== eo) bad++;
    end
    chk("bp_data_bad", 64'(bad), 64'd0);

    // Reset in the middle of a matrix stream.
    for (int i = 0; i < 64; i++) wbuf[i] = i + 1;
    send_cmd(2'd0);
    send_words(64, 1'b0);
    repeat (5) tick();
    chk("mid_stream_data", 64'(mvm_data_in), 64'd5);
    reset = 1'b1;
    tick();
    chk("mid_rst_outs", 64'({cmd_ready, in_ready, out_valid, err, busy,
        mvm_loadMatrix, mvm_loadVector, mvm_start}), 64'd0);
    chk("mid_rst_data", 64'({mvm_data_in, out_data}), 64'd0);
    reset = 1'b0;
    tick();
    e0 = err_cnt;
    s0 = st_cnt;
    send_cmd(2'd2);
    repeat (3) tick();
    chk("post_rst_err", 64'(err_cnt - e0), 64'd1);
    chk("post_rst_nostart", 64'(st_cnt), 64'(s0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
